// File: rtl/arp_req_arb.sv
// rtl/arp_req_arb.sv - round-robin arbiter sharing one ARP lookup port among PORTS requesters
//
// Purpose:
//   Grants the single ARP lookup interface to one requester at a time, holds
//   that grant through the request and response handshakes, and routes the
//   response back to the granted requester only. One lookup is outstanding.
//
// Ports:
//   clk, rst                  clock (rising edge) and synchronous active-low reset
//   s_arp_request_*           per-requester request: valid/ready bit vectors, packed IPs
//   s_arp_response_*          per-requester response: one-hot valid, ready vector,
//                             broadcast error/mac qualified by valid
//   m_arp_request_*           request toward the ARP block (latched IP)
//   m_arp_response_*          response from the ARP block
//   busy                      high while a lookup is in flight (REQ or RESP)
//   grant_index               index of the current or most recently granted port

module arp_req_arb #(
  parameter int PORTS     = 4,
  parameter int SEL_WIDTH = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PORTS-1:0]     s_arp_request_valid,
  output logic [PORTS-1:0]     s_arp_request_ready,
  input  logic [PORTS*32-1:0]  s_arp_request_ip,
  output logic [PORTS-1:0]     s_arp_response_valid,
  input  logic [PORTS-1:0]     s_arp_response_ready,
  output logic                 s_arp_response_error,
  output logic [47:0]          s_arp_response_mac,
  output logic                 m_arp_request_valid,
  input  logic                 m_arp_request_ready,
  output logic [31:0]          m_arp_request_ip,
  input  logic                 m_arp_response_valid,
  output logic                 m_arp_response_ready,
  input  logic                 m_arp_response_error,
  input  logic [47:0]          m_arp_response_mac,
  output logic                 busy,
  output logic [SEL_WIDTH-1:0] grant_index
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state;
  state_t               next_state;

  // rr_ptr is the highest-priority port for the next arbitration; it moves to
  // one past the served port when a lookup completes.
  logic [SEL_WIDTH-1:0] rr_ptr;
  logic [SEL_WIDTH-1:0] rr_ptr_next;

  logic                 found;
  logic [SEL_WIDTH-1:0] winner;
  logic [31:0]          winner_ip;

  logic                 resp_hs;

  // Rotating priority scan starting at rr_ptr, wrapping modulo PORTS.
  always_comb begin
    int idx;
    found     = 1'b0;
    winner    = '0;
    winner_ip = '0;
    idx       = 0;
    for (int k = 0; k < PORTS; k++) begin
      idx = (int'(rr_ptr) + k) % PORTS;
      if (!found && s_arp_request_valid[idx]) begin
        found     = 1'b1;
        winner    = SEL_WIDTH'(idx);
        winner_ip = s_arp_request_ip[32*idx +: 32];
      end
    end
  end

  assign resp_hs = (state == RESP) && m_arp_response_valid && m_arp_response_ready;

  always_comb begin
    if (int'(grant_index) >= PORTS - 1) begin
      rr_ptr_next = '0;
    end else begin
      rr_ptr_next = grant_index + SEL_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_index      <= '0;
      rr_ptr           <= '0;
      m_arp_request_ip <= '0;
    end else begin
      if (state == IDLE && found) begin
        grant_index      <= winner;
        m_arp_request_ip <= winner_ip;
      end
      if (resp_hs) begin
        rr_ptr <= rr_ptr_next;
      end
    end
  end

  always_comb begin
    next_state           = state;
    s_arp_request_ready  = '0;
    s_arp_response_valid = '0;
    m_arp_response_ready = 1'b0;
    m_arp_request_valid  = 1'b0;
    busy                 = (state != IDLE);

    case (state)
      IDLE: begin
        for (int i = 0; i < PORTS; i++) begin
          s_arp_request_ready[i] = found && (winner == SEL_WIDTH'(i));
        end
        if (found) begin
          next_state = REQ;
        end
      end
      REQ: begin
        m_arp_request_valid = 1'b1;
        if (m_arp_request_ready) begin
          next_state = RESP;
        end
      end
      RESP: begin
        for (int i = 0; i < PORTS; i++) begin
          s_arp_response_valid[i] = m_arp_response_valid && (grant_index == SEL_WIDTH'(i));
        end
        m_arp_response_ready = s_arp_response_ready[grant_index];
        if (m_arp_response_valid && s_arp_response_ready[grant_index]) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Broadcast; only meaningful where s_arp_response_valid is set.
  assign s_arp_response_error = m_arp_response_error;
  assign s_arp_response_mac   = m_arp_response_mac;

endmodule

// File: tb/tb_arp_req_arb.sv
// tb/tb_arp_req_arb.sv - scoreboard bench for arp_req_arb

module tb_arp_req_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   s_arp_request_valid;
  logic [3:0]   s_arp_request_ready;
  logic [127:0] s_arp_request_ip;
  logic [3:0]   s_arp_response_valid;
  logic [3:0]   s_arp_response_ready;
  logic         s_arp_response_error;
  logic [47:0]  s_arp_response_mac;
  logic         m_arp_request_valid;
  logic         m_arp_request_ready;
  logic [31:0]  m_arp_request_ip;
  logic         m_arp_response_valid;
  logic         m_arp_response_ready;
  logic         m_arp_response_error;
  logic [47:0]  m_arp_response_mac;
  logic         busy;
  logic [1:0]   grant_index;

  arp_req_arb #(.PORTS(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_arp_request_valid  (s_arp_request_valid),
    .s_arp_request_ready  (s_arp_request_ready),
    .s_arp_request_ip     (s_arp_request_ip),
    .s_arp_response_valid (s_arp_response_valid),
    .s_arp_response_ready (s_arp_response_ready),
    .s_arp_response_error (s_arp_response_error),
    .s_arp_response_mac   (s_arp_response_mac),
    .m_arp_request_valid  (m_arp_request_valid),
    .m_arp_request_ready  (m_arp_request_ready),
    .m_arp_request_ip     (m_arp_request_ip),
    .m_arp_response_valid (m_arp_response_valid),
    .m_arp_response_ready (m_arp_response_ready),
    .m_arp_response_error (m_arp_response_error),
    .m_arp_response_mac   (m_arp_response_mac),
    .busy                 (busy),
    .grant_index          (grant_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] ip;
    logic [47:0] mac;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   ptr    = 0;   // model: highest-priority port for the next lookup

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int p);
    logic [3:0] r;
    r = 4'b0001 << p;
    return r;
  endfunction

  // Model arbitration: first requesting port at or after ptr, with wrap.
  function automatic int pick(input logic [3:0] mask, input int p0);
    for (int k = 0; k < 4; k++) begin
      if (mask[(p0 + k) % 4]) return (p0 + k) % 4;
    end
    return -1;
  endfunction

  // Monitor: compares every DUT handshake against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (|s_arp_request_ready) begin
        chk("req_ready_subset", s_arp_request_ready & ~s_arp_request_valid, 0);
        if (exp_q.size() == 0) chk("req_ready_unexpected", s_arp_request_ready, 0);
        else chk("req_ready_winner", s_arp_request_ready, oh(exp_q[0].port));
      end
      if (m_arp_request_valid && m_arp_request_ready && exp_q.size() > 0)
        chk("req_ip", m_arp_request_ip, exp_q[0].ip);
      if (m_arp_response_valid && m_arp_response_ready) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          chk("resp_valid_route", s_arp_response_valid, oh(exp_q[0].port));
          chk("resp_mac", s_arp_response_mac, exp_q[0].mac);
          chk("resp_err", s_arp_response_error, exp_q[0].err);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    s_arp_request_valid  = '0;
    s_arp_response_ready = '0;
    m_arp_request_ready  = 1'b0;
    m_arp_response_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    ptr = 0;
    exp_q.delete();
  endtask

  task automatic lookup(input logic [3:0] mask, input logic [127:0] ips, input logic [47:0] mac,
                        input logic err, input int req_dly, input int resp_dly, input int rdy_dly,
                        input bit abort);
    int w;
    int n;
    exp_t e;
    @(posedge clk); #1;
    w = pick(mask, ptr);
    e.port = w; e.ip = ips[32*w +: 32]; e.mac = mac; e.err = err;
    exp_q.push_back(e);
    s_arp_request_valid = mask;
    s_arp_request_ip    = ips;
    n = 0;
    @(negedge clk);
    while (!(|s_arp_request_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
    s_arp_request_valid = '0;
    @(negedge clk);
    chk("req_valid_latency", m_arp_request_valid, 1);
    chk("busy_req", busy, 1);
    // Request stall: valid/ip hold, and no requester is accepted even if valid.
    repeat (req_dly) begin
      @(posedge clk); #1;
      s_arp_request_valid = 4'($urandom);
      @(negedge clk);
      chk("req_hold_valid", m_arp_request_valid, 1);
      chk("req_hold_ip", m_arp_request_ip, e.ip);
      chk("req_no_ready", s_arp_request_ready, 0);
    end
    @(posedge clk); #1;
    m_arp_request_ready = 1'b1;
    @(negedge clk);
    chk("req_valid_at_hs", m_arp_request_valid, 1);
    @(posedge clk); #1;
    m_arp_request_ready = 1'b0;
    @(negedge clk);
    chk("req_valid_drop", m_arp_request_valid, 0);
    repeat (resp_dly) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    m_arp_response_valid = 1'b1;
    m_arp_response_mac   = mac;
    m_arp_response_error = err;
    s_arp_response_ready = 4'($urandom) & ~oh(w);
    repeat (rdy_dly) begin
      @(negedge clk);
      chk("resp_stall_valid", s_arp_response_valid, oh(w));
      chk("resp_stall_mready", m_arp_response_ready, 0);
      chk("resp_no_req_ready", s_arp_request_ready, 0);
      @(posedge clk); #1;
    end
    if (abort) begin
      rst = 1'b0;
      m_arp_response_valid = 1'b0;
      s_arp_response_ready = '0;
      s_arp_request_valid  = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      void'(exp_q.pop_front());
      ptr = 0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_grant", grant_index, 0);
      chk("abort_m_valid", m_arp_request_valid, 0);
      chk("abort_resp_valid", s_arp_response_valid, 0);
      chk("abort_m_resp_ready", m_arp_response_ready, 0);
      return;
    end
    s_arp_response_ready = s_arp_response_ready | oh(w);
    n = 0;
    @(negedge clk);
    while (!m_arp_response_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("resp_timeout", 1, 0);
    @(posedge clk); #1;
    m_arp_response_valid = 1'b0;
    s_arp_response_ready = '0;
    s_arp_request_valid  = '0;
    ptr = (w + 1) % 4;
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("grant_index", grant_index, w);
  endtask

  initial begin
    rst                  = 1'b0;
    s_arp_request_valid  = '0;
    s_arp_request_ip     = '0;
    s_arp_response_ready = '0;
    m_arp_request_ready  = 1'b0;
    m_arp_response_valid = 1'b0;
    m_arp_response_error = 1'b0;
    m_arp_response_mac   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_index, 0);
    chk("rst_m_valid", m_arp_request_valid, 0);
    chk("rst_m_ip", m_arp_request_ip, 0);
    chk("rst_s_ready", s_arp_request_ready, 0);
    chk("rst_m_resp_ready", m_arp_response_ready, 0);

    // T1: port 2 single lookup
    lookup(4'b0100, {32'h0, 32'hC0A80105, 32'h0, 32'h0}, 48'h5A5152535455, 1'b0, 0, 1, 0, 1'b0);

    // T2: all ports requesting after reset -> 0,1,2,3,0,1,2,3
    do_reset();
    for (int i = 0; i < 8; i++) begin
      lookup(4'hF, {$urandom, $urandom, $urandom, $urandom}, 48'({$urandom, $urandom}),
             1'($urandom), 0, 0, 0, 1'b0);
      chk("t2_order", grant_index, i % 4);
    end

    // T3: request stall of 10 cycles
    lookup(4'b1000, {$urandom, $urandom, $urandom, $urandom}, 48'h0123456789AB, 1'b0, 10, 0, 0, 1'b0);

    // T4: error response with port 1 stalling 5 cycles
    lookup(4'b0010, {$urandom, $urandom, $urandom, $urandom}, 48'h0, 1'b1, 0, 0, 5, 1'b0);

    // T6: stray response while idle
    @(posedge clk); #1;
    m_arp_response_valid = 1'b1;
    s_arp_response_ready = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("stray_m_resp_ready", m_arp_response_ready, 0);
      chk("stray_resp_valid", s_arp_response_valid, 0);
      @(posedge clk); #1;
    end
    m_arp_response_valid = 1'b0;
    s_arp_response_ready = '0;

    // T5: reset while in RESP, then port 3 served normally
    lookup(4'b0010, {$urandom, $urandom, $urandom, $urandom}, 48'hAAAA5555AAAA, 1'b0, 0, 0, 2, 1'b1);
    lookup(4'b1000, {32'hC0A80003, $urandom, $urandom, $urandom}, 48'h112233445566, 1'b0, 0, 0, 0, 1'b0);

    // Randomized lookups
    for (int i = 0; i < 30; i++) begin
      lookup(4'($urandom_range(1, 15)), {$urandom, $urandom, $urandom, $urandom},
             48'({$urandom, $urandom}), 1'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
